// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack defaults, the stack operation decode and the
// stack-fault codes used by the CPU trap logic.
package cpu_pkg;

  localparam int DEFAULT_WIDTH_DATA = 32;
  localparam int DEFAULT_DEPTH      = 32;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_t;

  localparam logic [1:0] STACK_FAULT_NONE      = 2'd0;
  localparam logic [1:0] STACK_FAULT_OVERFLOW  = 2'd1;
  localparam logic [1:0] STACK_FAULT_UNDERFLOW = 2'd2;

  function automatic stack_op_t decode_op(input logic push, input logic pop);
    return stack_op_t'({pop, push});
  endfunction

endpackage

// File: rtl/operand_stack_mem.sv
// Stack entry register file: one synchronous write port, two asynchronous
// read ports (TOS, NOS). Data is never reset; the parent masks by count.
module operand_stack_mem
  import cpu_pkg::*;
#(
  parameter  int WIDTH_DATA = DEFAULT_WIDTH_DATA,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [PTR_W-1:0]      i_waddr,
  input  logic [WIDTH_DATA-1:0] i_wdata,
  input  logic [PTR_W-1:0]      i_tos_idx,
  input  logic [PTR_W-1:0]      i_nos_idx,
  output logic [WIDTH_DATA-1:0] o_tos,
  output logic [WIDTH_DATA-1:0] o_nos
);

  logic [WIDTH_DATA-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_tos = r_mem[i_tos_idx];
  assign o_nos = r_mem[i_nos_idx];

endmodule

// File: rtl/operand_stack.sv
// LIFO operand/return stack with TOS/NOS read-out, status and sticky errors.
// Optional high-water output enabled by OPERAND_STACK_HIGH_WATER_EN.
module operand_stack
  import cpu_pkg::*;
#(
  parameter  int WIDTH_DATA = DEFAULT_WIDTH_DATA,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH_DATA-1:0] data_in,
  input  logic                  clear_err,
  output logic [WIDTH_DATA-1:0] data_out,
  output logic [WIDTH_DATA-1:0] nos_out,
  output logic [PTR_W:0]        count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
`ifdef OPERAND_STACK_HIGH_WATER_EN
  output logic [PTR_W:0]        high_water,
`endif
  output logic                  underflow
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("operand_stack: DEPTH must be a power of two and at least 2");
  end

  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]        r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  stack_op_t             w_op;
  logic                  w_full;
  logic                  w_empty;
  logic [PTR_W-1:0]      w_push_idx;
  logic [PTR_W-1:0]      w_tos_idx;
  logic [PTR_W-1:0]      w_nos_idx;
  logic                  w_we;
  logic [PTR_W-1:0]      w_waddr;
  logic [PTR_W:0]        w_count_nxt;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic [WIDTH_DATA-1:0] w_tos;
  logic [WIDTH_DATA-1:0] w_nos;

  assign w_op       = decode_op(push, pop);
  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == '0);
  // Indices are only meaningful while count covers them; outputs are masked.
  assign w_push_idx = PTR_W'(r_count);
  assign w_tos_idx  = PTR_W'(r_count - CNT_ONE);
  assign w_nos_idx  = PTR_W'(r_count - CNT_TWO);

  always_comb begin
    w_we        = 1'b0;
    w_waddr     = w_push_idx;
    w_count_nxt = r_count;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    case (w_op)
      OP_PUSH: begin
        if (w_full) begin
          w_ovf_set = 1'b1;
        end else begin
          w_we        = 1'b1;
          w_count_nxt = r_count + CNT_ONE;
        end
      end
      OP_POP: begin
        if (w_empty) begin
          w_unf_set = 1'b1;
        end else begin
          w_count_nxt = r_count - CNT_ONE;
        end
      end
      OP_REPLACE: begin
        w_we = 1'b1;
        if (w_empty) begin
          // Nothing to pop: the push still lands at entry 0.
          w_count_nxt = CNT_ONE;
          w_unf_set   = 1'b1;
        end else begin
          w_waddr = w_tos_idx;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_overflow  <= (r_overflow  & ~clear_err) | w_ovf_set;
      r_underflow <= (r_underflow & ~clear_err) | w_unf_set;
    end
  end

  operand_stack_mem #(
    .WIDTH_DATA (WIDTH_DATA),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (data_in),
    .i_tos_idx (w_tos_idx),
    .i_nos_idx (w_nos_idx),
    .o_tos     (w_tos),
    .o_nos     (w_nos)
  );

  assign data_out  = w_empty ? '0 : w_tos;
  assign nos_out   = (r_count >= CNT_TWO) ? w_nos : '0;
  assign count     = r_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

`ifdef OPERAND_STACK_HIGH_WATER_EN
  logic [PTR_W:0] r_high_water;

  // Tracks the registered count, so it trails a rising count by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_high_water <= '0;
    end else if (clear_err) begin
      r_high_water <= r_count;
    end else if (r_count > r_high_water) begin
      r_high_water <= r_count;
    end
  end

  assign high_water = r_high_water;
`endif

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: queue-based reference model checked
// every cycle, plus directed literal expectations.
module tb_operand_stack;

  localparam int W     = 32;
  localparam int DEPTH = 32;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [W-1:0]     data_in = '0;
  logic             clear_err = 1'b0;
  logic [W-1:0]     data_out;
  logic [W-1:0]     nos_out;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
`ifdef OPERAND_STACK_HIGH_WATER_EN
  logic [PTR_W:0]   high_water;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  operand_stack #(.WIDTH_DATA(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .clear_err (clear_err),
    .data_out  (data_out),
    .nos_out   (nos_out),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
`ifdef OPERAND_STACK_HIGH_WATER_EN
    .high_water(high_water),
`endif
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue with the stack's rules applied per edge.
  int unsigned q[$];
  bit          m_ovf, m_unf;
  int          m_hw;

  always @(posedge clk or negedge rst) begin : model
    bit e_ovf, e_unf;
    int prev;
    if (!rst) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_hw  = 0;
    end else begin
      e_ovf = 0;
      e_unf = 0;
      prev  = q.size();
      if (push && pop) begin
        if (q.size() == 0) begin
          q.push_back(data_in);
          e_unf = 1;
        end else begin
          q[q.size()-1] = data_in;
        end
      end else if (push) begin
        if (q.size() == DEPTH) e_ovf = 1;
        else q.push_back(data_in);
      end else if (pop) begin
        if (q.size() == 0) e_unf = 1;
        else void'(q.pop_back());
      end
      if (clear_err) m_hw = prev;
      else if (prev > m_hw) m_hw = prev;
      if (clear_err) begin
        m_ovf = 0;
        m_unf = 0;
      end
      m_ovf = m_ovf | e_ovf;
      m_unf = m_unf | e_unf;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("m_count", 64'(count), 64'(q.size()));
      chk("m_data_out", 64'(data_out), 64'(q.size() >= 1 ? q[q.size()-1] : 0));
      chk("m_nos_out", 64'(nos_out), 64'(q.size() >= 2 ? q[q.size()-2] : 0));
      chk("m_full", 64'(full), 64'(q.size() == DEPTH));
      chk("m_empty", 64'(empty), 64'(q.size() == 0));
      chk("m_overflow", 64'(overflow), 64'(m_ovf));
      chk("m_underflow", 64'(underflow), 64'(m_unf));
`ifdef OPERAND_STACK_HIGH_WATER_EN
      chk("m_high_water", 64'(high_water), 64'(m_hw));
`endif
    end
  end

  // One operation: inputs held across the next rising edge, then idle.
  task automatic op(input logic p, input logic po, input logic [W-1:0] d, input logic c);
    push = p; pop = po; data_in = d; clear_err = c;
    @(posedge clk); #1;
    push = 0; pop = 0; data_in = '0; clear_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_flags", 64'({overflow, underflow, full}), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    chk("reset_data_out", 64'(data_out), 64'd0);
    chk("reset_nos_out", 64'(nos_out), 64'd0);

    // Push 5, 7, 9 then pop.
    op(1, 0, 5, 0); op(1, 0, 7, 0); op(1, 0, 9, 0);
    chk("p3_tos", 64'(data_out), 64'd9);
    chk("p3_nos", 64'(nos_out), 64'd7);
    chk("p3_count", 64'(count), 64'd3);
    chk("p3_empty", 64'(empty), 64'd0);
    op(0, 1, 0, 0);
    chk("pop_tos", 64'(data_out), 64'd7);
    chk("pop_nos", 64'(nos_out), 64'd5);
    chk("pop_count", 64'(count), 64'd2);

    // Replace TOS at count 3.
    op(1, 0, 9, 0);
    op(1, 1, 32'hDEAD, 0);
    chk("rep_tos", 64'(data_out), 64'hDEAD);
    chk("rep_nos", 64'(nos_out), 64'd7);
    chk("rep_count", 64'(count), 64'd3);
    chk("rep_flags", 64'({overflow, underflow}), 64'd0);

    // Fill, overflow, replace while full, clear.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) op(1, 0, W'(i), 0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_tos", 64'(data_out), 64'd32);
    op(1, 0, 99, 0);
    chk("ovf_tos", 64'(data_out), 64'd32);
    chk("ovf_count", 64'(count), 64'd32);
    chk("ovf_flag", 64'(overflow), 64'd1);
    op(1, 1, 77, 0);
    chk("fullrep_tos", 64'(data_out), 64'd77);
    chk("fullrep_nos", 64'(nos_out), 64'd31);
    op(0, 0, 0, 1);
    chk("clr_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < DEPTH + 1; i++) op(0, 1, 0, 0);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_unf", 64'(underflow), 64'd1);
    op(0, 1, 0, 1);
    chk("clr_vs_new_err", 64'(underflow), 64'd1);

    // Underflow on empty, then push+pop on empty.
    do_reset();
    op(0, 1, 0, 0);
    chk("unf_flag", 64'(underflow), 64'd1);
    chk("unf_count", 64'(count), 64'd0);
    chk("unf_tos", 64'(data_out), 64'd0);
    op(1, 1, 4, 0);
    chk("erep_count", 64'(count), 64'd1);
    chk("erep_tos", 64'(data_out), 64'd4);
    chk("erep_unf", 64'(underflow), 64'd1);

    // Asynchronous reset in the middle of a push.
    op(1, 0, 1, 0); op(1, 0, 2, 0);
    push = 1; data_in = 3;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_tos", 64'(data_out), 64'd0);
    chk("arst_flags", 64'({overflow, underflow}), 64'd0);
    push = 0; data_in = 0;
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    op(1, 0, 3, 0);
    chk("post_rst_tos", 64'(data_out), 64'd3);
    chk("post_rst_count", 64'(count), 64'd1);

`ifdef OPERAND_STACK_HIGH_WATER_EN
    do_reset();
    for (int i = 0; i < 4; i++) op(1, 0, W'(10 + i), 0);
    for (int i = 0; i < 3; i++) op(0, 1, 0, 0);
    chk("hw_peak", 64'(high_water), 64'd4);
    chk("hw_count", 64'(count), 64'd1);
    op(0, 0, 0, 1);
    chk("hw_clear", 64'(high_water), 64'd1);
`endif

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
